// File: rtl/lsu_align_if.sv
// lsu_align_if
//  Bundles the request, response and data-memory signals of the load/store
//  alignment unit so the unit and its environment connect through one port.
//
//  Request  : req_valid/req_ready handshake, req_we, req_size, req_unsigned,
//             req_addr (byte address), req_wdata (right-aligned store data)
//  Response : rsp_valid (one-cycle pulse), rsp_err, rsp_rdata (extended load data)
//  Memory   : mem_addr (word index), mem_wd, mem_we, mem_rd (combinational read data)
//
//  slave  : view taken by lsu_align
//  master : view taken by whatever issues requests and models the memory
interface lsu_align_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wd, mem_we
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wd, mem_we
    );

endinterface

// File: rtl/lsu_align.sv
// lsu_align
//  Load/store alignment unit between execute and a word-wide data memory.
//  Takes byte-addressed byte/half/word loads and stores (aligned or not),
//  turns them into one or two word accesses, does read-modify-write for
//  partial-word stores and sign/zero-extends load results.
//
//  Ports
//   clk     : clock, all state on the rising edge
//   rst     : asynchronous active-high reset, aborts any request in flight
//   lsu_if  : lsu_align_if.slave carrying request, response and memory signals
//
//  Parameters
//   MEM_WORDS : number of words in data memory; larger word indices are errors
module lsu_align #(
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic       clk,
    input  logic       rst,
    lsu_align_if.slave lsu_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } state_e;

    state_e      state_q, state_d;

    logic        accept;
    logic [1:0]  reqOff;
    logic [2:0]  reqBytes;
    logic [31:0] reqWord;
    logic        reqSplit;
    logic        reqErr;

    logic        we_q;
    logic        uns_q;
    logic        err_q;
    logic        split_q;
    logic [1:0]  off_q;
    logic [2:0]  bytes_q;
    logic [31:0] wordIdx_q;
    logic [31:0] wdata_q;
    logic [31:0] gather_q, gather_d;

    logic [3:0]  phaseBase;
    logic [3:0]  lanePos;
    logic [3:0]  laneRel;

    logic        lastPhase;
    logic [31:0] loadData;

    logic        rspValid_q;
    logic        rspErr_q;
    logic [31:0] rspRdata_q;

    // Decode the incoming request. The word index is kept at 32 bits so that
    // the "next word" check below cannot wrap around to a small legal index.
    always_comb begin
        accept   = (state_q == IDLE) && lsu_if.req_valid;
        reqOff   = lsu_if.req_addr[1:0];
        case (lsu_if.req_size)
            2'b00:   reqBytes = 3'd1;
            2'b01:   reqBytes = 3'd2;
            default: reqBytes = 3'd4;
        endcase
        reqWord  = {2'b00, lsu_if.req_addr[31:2]};
        reqSplit = ({2'b00, reqOff} + {1'b0, reqBytes}) > 4'd4;
        reqErr   = (lsu_if.req_size == 2'b11)
                || (reqWord >= MEM_WORDS)
                || (reqSplit && ((reqWord + 32'd1) >= MEM_WORDS));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Error requests never go to the second phase because
    // split_q is cleared for them at accept time.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = lsu_if.req_valid ? ACC0 : IDLE;
            ACC0:    state_d = split_q ? ACC1 : IDLE;
            ACC1:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. In each access phase every lane is classified by its byte
    // position across the two-word window (phaseBase + lane); a lane whose
    // position falls in [off, off+bytes) belongs to this request, and its
    // offset from off is the byte number within the request data. Targeted
    // lanes take store data and feed the load gather; untargeted lanes echo
    // mem_rd so a store always writes back a full, merged word.
    always_comb begin
        lsu_if.req_ready = (state_q == IDLE);
        lsu_if.rsp_valid = rspValid_q;
        lsu_if.rsp_err   = rspErr_q;
        lsu_if.rsp_rdata = rspRdata_q;
        lsu_if.mem_addr  = 32'd0;
        lsu_if.mem_wd    = 32'd0;
        lsu_if.mem_we    = 1'b0;
        gather_d         = gather_q;
        phaseBase        = 4'd0;
        lanePos          = 4'd0;
        laneRel          = 4'd0;
        if (state_q != IDLE) begin
            phaseBase       = (state_q == ACC1) ? 4'd4 : 4'd0;
            lsu_if.mem_addr = (state_q == ACC1) ? (wordIdx_q + 32'd1) : wordIdx_q;
            lsu_if.mem_we   = we_q && !err_q;
            lsu_if.mem_wd   = lsu_if.mem_rd;
            for (int lane = 0; lane < 4; lane++) begin
                lanePos = 4'(lane) + phaseBase;
                laneRel = lanePos - {2'b00, off_q};
                if ((lanePos >= {2'b00, off_q}) && (laneRel < {1'b0, bytes_q})) begin
                    lsu_if.mem_wd[8*lane +: 8]      = wdata_q[8*laneRel[1:0] +: 8];
                    gather_d[8*laneRel[1:0] +: 8]   = lsu_if.mem_rd[8*lane +: 8];
                end
            end
        end
    end

    // Extend the gathered load bytes, including those captured in the current
    // phase, so the final result is ready to register at the last phase.
    always_comb begin
        lastPhase = (state_q == ACC1) || ((state_q == ACC0) && !split_q);
        case (bytes_q)
            3'd1:    loadData = uns_q ? {24'd0, gather_d[7:0]}
                                      : {{24{gather_d[7]}}, gather_d[7:0]};
            3'd2:    loadData = uns_q ? {16'd0, gather_d[15:0]}
                                      : {{16{gather_d[15]}}, gather_d[15:0]};
            default: loadData = gather_d;
        endcase
    end

    // Request capture and gather accumulation. The gather register is cleared
    // on every accept so bytes from an earlier load never leak into a result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            split_q   <= 1'b0;
            off_q     <= 2'd0;
            bytes_q   <= 3'd0;
            wordIdx_q <= 32'd0;
            wdata_q   <= 32'd0;
            gather_q  <= 32'd0;
        end else if (accept) begin
            we_q      <= lsu_if.req_we;
            uns_q     <= lsu_if.req_unsigned;
            err_q     <= reqErr;
            split_q   <= reqSplit && !reqErr;
            off_q     <= reqOff;
            bytes_q   <= reqBytes;
            wordIdx_q <= reqWord;
            wdata_q   <= lsu_if.req_wdata;
            gather_q  <= 32'd0;
        end else begin
            gather_q  <= gather_d;
        end
    end

    // Registered response: a one-cycle pulse in the first idle cycle after
    // the last access phase. Read data holds until the next response and is
    // forced to zero for stores and errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspRdata_q <= 32'd0;
        end else begin
            rspValid_q <= lastPhase;
            rspErr_q   <= lastPhase && err_q;
            if (lastPhase) begin
                rspRdata_q <= (we_q || err_q) ? 32'd0 : loadData;
            end
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align
//  Drives lsu_align through its interface against a word-wide memory model.
//  Expected results come from a byte-addressed reference memory updated with
//  plain little-endian byte arithmetic, plus directed constants for the
//  documented examples.
module tb_lsu_align;

    logic clk;
    logic rst;

    lsu_align_if bus ();

    lsu_align #(
        .MEM_WORDS(4096)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .lsu_if (bus)
    );

    logic [31:0] mem [0:4095];
    logic [7:0]  refMem [0:16383];

    logic        initEn;
    logic [11:0] initIdx;
    logic [31:0] initData;

    int testsRun;
    int testsFailed;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory read port: combinational, out-of-range words read as zero.
    always_comb begin
        bus.mem_rd = (bus.mem_addr < 32'd4096) ? mem[bus.mem_addr[11:0]] : 32'd0;
    end

    // Memory write port: bench preloads take priority, otherwise DUT writes.
    always @(posedge clk) begin
        if (initEn) begin
            mem[initIdx] <= initData;
        end else if (bus.mem_we && (bus.mem_addr < 32'd4096)) begin
            mem[bus.mem_addr[11:0]] <= bus.mem_wd;
        end
    end

    // Single comparison point: counts the test and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Preload one memory word and mirror it into the reference byte memory.
    task automatic pokeWord(input int idx, input logic [31:0] val);
        @(negedge clk);
        initEn   = 1'b1;
        initIdx  = idx[11:0];
        initData = val;
        @(negedge clk);
        initEn   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            refMem[idx*4 + k] = val[8*k +: 8];
        end
    endtask

    function automatic logic [31:0] refWord(input int idx);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            w[8*k +: 8] = refMem[idx*4 + k];
        end
        return w;
    endfunction

    // Issue one request, predict its outcome from the reference memory, then
    // watch the DUT for the response counting cycles and write pulses.
    task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] gotData);
        longint unsigned a64;
        longint unsigned firstW;
        longint unsigned lastW;
        int          n;
        bit          expErr;
        bit          split;
        int          expLat;
        int          expWe;
        int          lat;
        int          weCnt;
        logic [31:0] raw;
        logic [31:0] expData;

        n      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        a64    = addr;
        firstW = a64 >> 2;
        lastW  = (a64 + longint'(n) - 1) >> 2;
        expErr = (size == 2'd3) || (firstW >= 4096) || (lastW >= 4096);
        split  = (lastW != firstW);
        expLat = (!expErr && split) ? 2 : 1;
        expWe  = (we && !expErr) ? (split ? 2 : 1) : 0;
        expData = 32'd0;
        raw     = 32'd0;
        if (!expErr) begin
            if (we) begin
                for (int k = 0; k < n; k++) refMem[int'(addr[13:0]) + k] = wdata[8*k +: 8];
            end else begin
                for (int k = 0; k < n; k++) raw[8*k +: 8] = refMem[int'(addr[13:0]) + k];
                if (n == 4 || uns) expData = raw;
                else if (n == 1)   expData = raw[7]  ? (raw | 32'hFFFF_FF00) : raw;
                else               expData = raw[15] ? (raw | 32'hFFFF_0000) : raw;
            end
        end

        @(negedge clk);
        checkOutput({tag, " ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat   = -1;
        weCnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.rsp_valid) begin
                lat = i;
                break;
            end
            if (bus.mem_we) weCnt++;
            @(posedge clk);
            #1;
        end
        gotData = bus.rsp_rdata;
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " we pulses"}, 32'(weCnt), 32'(expWe));
        checkOutput({tag, " err"}, {31'd0, bus.rsp_err}, {31'd0, expErr});
        checkOutput({tag, " rdata"}, bus.rsp_rdata, expData);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] rAddr;
        logic [1:0]  rSize;
        int          region;
        int          badCnt;

        testsRun         = 0;
        testsFailed      = 0;
        initEn           = 1'b0;
        initIdx          = 12'd0;
        initData         = 32'd0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        rst              = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset ready",     {31'd0, bus.req_ready}, 32'd1);
        checkOutput("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        checkOutput("reset rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        checkOutput("reset rsp_rdata", bus.rsp_rdata,          32'd0);
        checkOutput("reset mem_we",    {31'd0, bus.mem_we},    32'd0);
        checkOutput("reset mem_addr",  bus.mem_addr,           32'd0);
        checkOutput("reset mem_wd",    bus.mem_wd,             32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 34; i++)    pokeWord(i, $urandom);
        for (int i = 4088; i < 4096; i++) pokeWord(i, $urandom);

        applyStimulus("st word 0x10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, got);
        applyStimulus("ld word 0x10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
        checkOutput("ld word 0x10 const", got, 32'hDEAD_BEEF);
        checkOutput("mem[4] const", mem[4], 32'hDEAD_BEEF);

        pokeWord(1, 32'h1122_3344);
        applyStimulus("st byte 0x06", 1'b1, 2'd0, 1'b0, 32'h06, 32'h0000_00AA, got);
        checkOutput("mem[1] rmw const", mem[1], 32'h11AA_3344);
        applyStimulus("ld byte s 0x06", 1'b0, 2'd0, 1'b0, 32'h06, 32'h0, got);
        checkOutput("ld byte s const", got, 32'hFFFF_FFAA);
        applyStimulus("ld byte u 0x06", 1'b0, 2'd0, 1'b1, 32'h06, 32'h0, got);
        checkOutput("ld byte u const", got, 32'h0000_00AA);

        applyStimulus("st half 0x0B", 1'b1, 2'd1, 1'b0, 32'h0B, 32'h0000_BEEF, got);
        checkOutput("mem[2] top byte", {24'd0, mem[2][31:24]}, 32'h0000_00EF);
        checkOutput("mem[3] low byte", {24'd0, mem[3][7:0]},   32'h0000_00BE);
        applyStimulus("ld half s 0x0B", 1'b0, 2'd1, 1'b0, 32'h0B, 32'h0, got);
        checkOutput("ld half s const", got, 32'hFFFF_BEEF);

        pokeWord(0, 32'h4433_2211);
        pokeWord(1, 32'h8877_6655);
        applyStimulus("ld word 0x01", 1'b0, 2'd2, 1'b0, 32'h01, 32'h0, got);
        checkOutput("ld word 0x01 const", got, 32'h5544_3322);

        applyStimulus("st word 0x3FFC", 1'b1, 2'd2, 1'b0, 32'h3FFC, 32'hCAFE_F00D, got);
        checkOutput("mem[4095] const", mem[4095], 32'hCAFE_F00D);
        applyStimulus("st word 0x3FFE", 1'b1, 2'd2, 1'b0, 32'h3FFE, 32'h1234_5678, got);
        applyStimulus("ld size 11", 1'b0, 2'd3, 1'b0, 32'h20, 32'h0, got);
        applyStimulus("ld word 0x4000", 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, got);
        applyStimulus("ld word top", 1'b0, 2'd2, 1'b1, 32'hFFFF_FFFE, 32'h0, got);

        // Abort a split store while its first write is on the bus.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h21;
        bus.req_wdata = 32'h5A5A_5A5A;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checkOutput("midop acc0 we", {31'd0, bus.mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midop rst we",    {31'd0, bus.mem_we},    32'd0);
        checkOutput("midop rst valid", {31'd0, bus.rsp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        badCnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.mem_we || bus.rsp_valid) badCnt++;
        end
        checkOutput("midop quiet after", 32'(badCnt), 32'd0);
        checkOutput("midop ready", {31'd0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 80; i++) begin
            region = $urandom_range(0, 9);
            if (region <= 6)      rAddr = 32'($urandom_range(0, 32'h7B));
            else if (region <= 8) rAddr = 32'h3FE0 + 32'($urandom_range(0, 31));
            else                  rAddr = ($urandom_range(0, 1) == 1) ? (32'h4000 + 32'($urandom_range(0, 15)))
                                                                     : (32'hFFFF_FFFC + 32'($urandom_range(0, 3)));
            rSize = 2'($urandom_range(0, 3));
            applyStimulus("rand", 1'($urandom_range(0, 1)), rSize, 1'($urandom_range(0, 1)),
                          rAddr, $urandom, got);
        end

        @(negedge clk);
        for (int i = 0; i < 34; i++)      checkOutput("mem word low", mem[i], refWord(i));
        for (int i = 4088; i < 4096; i++) checkOutput("mem word top", mem[i], refWord(i));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
